// File: rtl/i2c_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_req_arbiter
//  Description : Round-robin arbiter that shares one byte-register I2C master
//                between NUM_REQ requesters, with a watchdog on hung transfers.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_req_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int TIMEOUT_CYC = 120000,
    parameter int TO_W        = 17
) (
    input  logic                   clk_i,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [NUM_REQ-1:0]     req_rw_i,
    input  logic [7*NUM_REQ-1:0]   req_dev_i,
    input  logic [8*NUM_REQ-1:0]   req_reg_i,
    input  logic [8*NUM_REQ-1:0]   req_wdata_i,
    output logic [NUM_REQ-1:0]     gnt_o,
    output logic [NUM_REQ-1:0]     done_o,
    output logic                   err_o,
    output logic [7:0]             rdata_o,
    output logic                   busy_o,
    output logic                   m_start_o,
    output logic                   m_rw_o,
    output logic [6:0]             m_dev_o,
    output logic [7:0]             m_reg_o,
    output logic [7:0]             m_wdata_o,
    input  logic                   m_busy_i,
    input  logic                   m_done_i,
    input  logic                   m_nack_i,
    input  logic [7:0]             m_rdata_i
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int SW = IW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IW-1:0]       r_ptr;
    logic [IW-1:0]       r_gidx;
    logic [NUM_REQ-1:0]  r_gnt;
    logic                r_err;
    logic [7:0]          r_rdata;
    logic                r_m_rw;
    logic [6:0]          r_m_dev;
    logic [7:0]          r_m_reg;
    logic [7:0]          r_m_wdata;
    logic [TO_W-1:0]     r_cnt;

    logic [IW-1:0]       w_win;
    logic                w_any;
    logic [SW-1:0]       w_sum;
    logic                w_timeout;
    logic [IW-1:0]       w_ptr_nxt;

    // Scan from the highest offset down so the requester closest to r_ptr wins.
    always_comb begin
        w_win = r_ptr;
        w_any = 1'b0;
        w_sum = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_sum = {1'b0, r_ptr} + SW'(i);
            if (w_sum >= SW'(NUM_REQ)) begin
                w_sum = w_sum - SW'(NUM_REQ);
            end
            if (req_i[w_sum[IW-1:0]]) begin
                w_win = w_sum[IW-1:0];
                w_any = 1'b1;
            end
        end
    end

    assign w_timeout = (r_cnt == TO_W'(TIMEOUT_CYC - 1));
    assign w_ptr_nxt = (r_gidx == IW'(NUM_REQ - 1)) ? '0 : r_gidx + IW'(1);

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any && !m_busy_i) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT:  if (m_done_i || w_timeout) w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            r_ptr     <= '0;
            r_gidx    <= '0;
            r_gnt     <= '0;
            r_err     <= 1'b0;
            r_rdata   <= '0;
            r_m_rw    <= 1'b0;
            r_m_dev   <= '0;
            r_m_reg   <= '0;
            r_m_wdata <= '0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any && !m_busy_i) begin
                        r_gidx    <= w_win;
                        r_gnt     <= NUM_REQ'(1) << w_win;
                        r_m_rw    <= req_rw_i[w_win];
                        r_m_dev   <= req_dev_i[7*w_win +: 7];
                        r_m_reg   <= req_reg_i[8*w_win +: 8];
                        r_m_wdata <= req_wdata_i[8*w_win +: 8];
                    end
                end
                S_ISSUE: begin
                    r_cnt <= '0;
                end
                S_WAIT: begin
                    // A completion in the same cycle as the watchdog expiry takes priority.
                    if (m_done_i) begin
                        r_rdata <= r_m_rw ? m_rdata_i : 8'h00;
                        r_err   <= m_nack_i;
                    end else if (w_timeout) begin
                        r_rdata <= 8'h00;
                        r_err   <= 1'b1;
                    end else if (r_cnt != {TO_W{1'b1}}) begin
                        r_cnt <= r_cnt + TO_W'(1);
                    end
                end
                S_RESP: begin
                    r_gnt <= '0;
                    r_ptr <= w_ptr_nxt;
                end
                default: begin
                    r_gnt <= '0;
                end
            endcase
        end
    end

    assign gnt_o     = r_gnt;
    assign done_o    = (r_state == S_RESP) ? r_gnt : '0;
    assign err_o     = (r_state == S_RESP) && r_err;
    assign rdata_o   = r_rdata;
    assign busy_o    = (r_state != S_IDLE);
    assign m_start_o = (r_state == S_ISSUE);
    assign m_rw_o    = r_m_rw;
    assign m_dev_o   = r_m_dev;
    assign m_reg_o   = r_m_reg;
    assign m_wdata_o = r_m_wdata;

endmodule
`default_nettype wire

// File: tb/tb_i2c_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_req_arbiter
//  Description : Directed scoreboard bench for i2c_req_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_req_arbiter;

    localparam int TOC = 16;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic [2:0]  req_i, req_rw_i;
    logic [20:0] req_dev_i;
    logic [23:0] req_reg_i, req_wdata_i;
    logic [2:0]  gnt_o, done_o;
    logic        err_o, busy_o, m_start_o, m_rw_o;
    logic [7:0]  rdata_o, m_reg_o, m_wdata_o, m_rdata_i;
    logic [6:0]  m_dev_o;
    logic        m_busy_i, m_done_i, m_nack_i;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [2:0] gnt;
        logic       rw;
        logic [6:0] dev;
        logic [7:0] rg;
        logic [7:0] wd;
    } start_t;

    typedef struct packed {
        logic [2:0] done;
        logic       err;
        logic       chk_rd;
        logic [7:0] rd;
    } done_t;

    start_t sq[$];
    done_t  dq[$];

    i2c_req_arbiter #(.NUM_REQ(3), .TIMEOUT_CYC(TOC), .TO_W(5)) dut (
        .clk_i(clk_i), .rst_n(rst_n),
        .req_i(req_i), .req_rw_i(req_rw_i), .req_dev_i(req_dev_i),
        .req_reg_i(req_reg_i), .req_wdata_i(req_wdata_i),
        .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
        .busy_o(busy_o), .m_start_o(m_start_o), .m_rw_o(m_rw_o),
        .m_dev_o(m_dev_o), .m_reg_o(m_reg_o), .m_wdata_o(m_wdata_o),
        .m_busy_i(m_busy_i), .m_done_i(m_done_i), .m_nack_i(m_nack_i),
        .m_rdata_i(m_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input int i, input logic rw, input logic [6:0] dev,
                           input logic [7:0] rg, input logic [7:0] wd);
        req_rw_i[i]          = rw;
        req_dev_i[7*i +: 7]  = dev;
        req_reg_i[8*i +: 8]  = rg;
        req_wdata_i[8*i +: 8] = wd;
    endtask

    task automatic init_fields();
        set_req(0, 1'b0, 7'h11, 8'h01, 8'h10);
        set_req(1, 1'b0, 7'h36, 8'h12, 8'hA5);
        set_req(2, 1'b0, 7'h21, 8'h33, 8'h44);
    endtask

    task automatic push_start(input logic [2:0] g, input logic rw, input logic [6:0] dev,
                              input logic [7:0] rg, input logic [7:0] wd);
        start_t s;
        s.gnt = g; s.rw = rw; s.dev = dev; s.rg = rg; s.wd = wd;
        sq.push_back(s);
    endtask

    task automatic push_done(input logic [2:0] d, input logic e, input logic c, input logic [7:0] rd);
        done_t x;
        x.done = d; x.err = e; x.chk_rd = c; x.rd = rd;
        dq.push_back(x);
    endtask

    task automatic wait_start(output int n, output logic seen);
        n = -1;
        seen = 1'b0;
        for (int i = 0; i <= 30; i++) begin
            if (done_o != 3'b000) seen = 1'b1;
            if (m_start_o) begin
                n = i;
                break;
            end
            step();
        end
        if (n < 0) chk("start_wait", 32'(m_start_o), 32'd1);
    endtask

    task automatic check_start(output start_t st);
        st = '0;
        if (sq.size() == 0) begin
            chk("unexpected_start", 32'(m_start_o), 32'd0);
            return;
        end
        st = sq.pop_front();
        chk("gnt",     32'(gnt_o),     32'(st.gnt));
        chk("m_rw",    32'(m_rw_o),    32'(st.rw));
        chk("m_dev",   32'(m_dev_o),   32'(st.dev));
        chk("m_reg",   32'(m_reg_o),   32'(st.rg));
        chk("m_wdata", 32'(m_wdata_o), 32'(st.wd));
    endtask

    // Master model for one transaction; lat < 0 means the master never answers.
    task automatic serve(input int lat, input logic nack, input logic [7:0] rd, input int hold,
                         input logic drop, input logic scramble, output int nwait);
        start_t st;
        done_t  de;
        logic   seen;
        wait_start(nwait, seen);
        chk("no_stray_done", 32'(seen), 32'd0);
        if (nwait < 0) return;
        check_start(st);
        step();
        m_busy_i = 1'b1;
        if (scramble) begin
            req_i     = 3'b000;
            req_rw_i  = 3'b000;
            req_dev_i = ~req_dev_i;
        end
        if (lat < 0) begin
            for (int i = 1; i < TOC; i++) step();
            chk("no_early_done", 32'(done_o), 32'd0);
            step();
        end else begin
            for (int i = 1; i < lat; i++) step();
            m_done_i  = 1'b1;
            m_nack_i  = nack;
            m_rdata_i = rd;
            step();
            m_done_i  = 1'b0;
            m_nack_i  = 1'b0;
            m_rdata_i = 8'h00;
        end
        if (drop) req_i = 3'b000;
        if (dq.size() == 0) begin
            chk("unexpected_done", 32'(done_o), 32'd0);
        end else begin
            de = dq.pop_front();
            chk("done",  32'(done_o), 32'(de.done));
            chk("err",   32'(err_o),  32'(de.err));
            if (de.chk_rd) chk("rdata", 32'(rdata_o), 32'(de.rd));
            chk("m_hold_wait", 32'(m_dev_o), 32'(st.dev));
        end
        m_busy_i = (hold > 0);
        step();
        chk("done_pulse", 32'(done_o), 32'd0);
        for (int h = 1; h < hold; h++) step();
        m_busy_i = 1'b0;
    endtask

    always @(negedge clk_i) begin
        if (m_start_o) chk("start_while_busy", 32'(m_busy_i), 32'd0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int     nw;
        start_t st;
        logic   seen;
        rst_n = 1'b0; req_i = 3'b111; req_rw_i = '0; req_dev_i = '0; req_reg_i = '0;
        req_wdata_i = '0; m_busy_i = 1'b0; m_done_i = 1'b0; m_nack_i = 1'b0; m_rdata_i = '0;
        init_fields();
        step(); step();
        chk("rst_gnt",   32'(gnt_o),     32'd0);
        chk("rst_done",  32'(done_o),    32'd0);
        chk("rst_err",   32'(err_o),     32'd0);
        chk("rst_rdata", 32'(rdata_o),   32'd0);
        chk("rst_busy",  32'(busy_o),    32'd0);
        chk("rst_start", 32'(m_start_o), 32'd0);
        chk("rst_m",     32'({m_rw_o, m_dev_o, m_reg_o, m_wdata_o}), 32'd0);
        rst_n = 1'b1;

        // Round-robin with all three requesting; master stays busy after each done.
        push_start(3'b001, 1'b0, 7'h11, 8'h01, 8'h10); push_done(3'b001, 1'b0, 1'b1, 8'h00);
        serve(3, 1'b0, 8'hEE, 3, 1'b0, 1'b0, nw);
        push_start(3'b010, 1'b0, 7'h36, 8'h12, 8'hA5); push_done(3'b010, 1'b0, 1'b1, 8'h00);
        serve(3, 1'b0, 8'hEE, 3, 1'b0, 1'b0, nw);
        push_start(3'b100, 1'b0, 7'h21, 8'h33, 8'h44); push_done(3'b100, 1'b0, 1'b1, 8'h00);
        serve(3, 1'b0, 8'hEE, 3, 1'b0, 1'b0, nw);
        push_start(3'b001, 1'b0, 7'h11, 8'h01, 8'h10); push_done(3'b001, 1'b0, 1'b1, 8'h00);
        serve(3, 1'b0, 8'hEE, 0, 1'b1, 1'b0, nw);

        // Single write on requester 1.
        req_i = 3'b010;
        push_start(3'b010, 1'b0, 7'h36, 8'h12, 8'hA5); push_done(3'b010, 1'b0, 1'b1, 8'h00);
        serve(5, 1'b0, 8'hEE, 0, 1'b1, 1'b0, nw);
        chk("gnt_latency", 32'(nw), 32'd1);
        step(); step();
        chk("m_hold_idle", 32'({m_dev_o, m_wdata_o}), 32'({7'h36, 8'hA5}));

        // Read on requester 0; request and fields disturbed after grant.
        set_req(0, 1'b1, 7'h50, 8'h07, 8'h99);
        req_i = 3'b001;
        push_start(3'b001, 1'b1, 7'h50, 8'h07, 8'h99); push_done(3'b001, 1'b0, 1'b1, 8'h5C);
        serve(4, 1'b0, 8'h5C, 0, 1'b1, 1'b1, nw);
        step(); step(); step();
        chk("rdata_hold", 32'(rdata_o), 32'h5C);

        // Watchdog on a read from requester 1.
        init_fields();
        set_req(1, 1'b1, 7'h36, 8'h12, 8'hA5);
        req_i = 3'b010;
        push_start(3'b010, 1'b1, 7'h36, 8'h12, 8'hA5); push_done(3'b010, 1'b1, 1'b1, 8'h00);
        serve(-1, 1'b0, 8'h00, 0, 1'b1, 1'b0, nw);

        // Stray master completion while idle.
        m_done_i = 1'b1; m_rdata_i = 8'hFF;
        step();
        m_done_i = 1'b0; m_rdata_i = 8'h00;
        chk("idle_done_ignored", 32'(done_o), 32'd0);
        step();
        chk("idle_rdata", 32'({done_o, busy_o, rdata_o}), 32'd0);

        // Next request after a timeout.
        init_fields();
        req_i = 3'b100;
        push_start(3'b100, 1'b0, 7'h21, 8'h33, 8'h44); push_done(3'b100, 1'b0, 1'b0, 8'h00);
        serve(3, 1'b0, 8'h00, 0, 1'b1, 1'b0, nw);

        // NACK, then completion coinciding with the watchdog expiry.
        req_i = 3'b001;
        push_start(3'b001, 1'b0, 7'h11, 8'h01, 8'h10); push_done(3'b001, 1'b1, 1'b0, 8'h00);
        serve(2, 1'b1, 8'h00, 0, 1'b1, 1'b0, nw);
        req_i = 3'b010;
        push_start(3'b010, 1'b0, 7'h36, 8'h12, 8'hA5); push_done(3'b010, 1'b0, 1'b0, 8'h00);
        serve(TOC, 1'b0, 8'h00, 0, 1'b1, 1'b0, nw);

        // Reset during WAIT drops the transaction and rewinds the pointer.
        req_i = 3'b110;
        push_start(3'b100, 1'b0, 7'h21, 8'h33, 8'h44);
        wait_start(nw, seen);
        check_start(st);
        step(); step();
        rst_n = 1'b0;
        step();
        chk("midrst_out", 32'({gnt_o, done_o, err_o, busy_o, m_start_o}), 32'd0);
        chk("midrst_m",   32'({m_rw_o, m_dev_o, m_reg_o, m_wdata_o}), 32'd0);
        rst_n = 1'b1;
        push_start(3'b010, 1'b0, 7'h36, 8'h12, 8'hA5); push_done(3'b010, 1'b0, 1'b1, 8'h00);
        serve(3, 1'b0, 8'hEE, 0, 1'b1, 1'b0, nw);
        chk("sq_empty", 32'(sq.size()), 32'd0);
        chk("dq_empty", 32'(dq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
